// File: rtl/sa_fusion_pkg.sv
// Shared types and helpers for the BitBrick fusion/accumulate datapath.
package sa_fusion_pkg;

    typedef enum logic [1:0] {
        P2 = 2'd0,
        P4 = 2'd1,
        P8 = 2'd2
    } prec_t;

    localparam int BB_W = 6;
    localparam int GRID = 4;

    // Left-shift applied to BitBrick product (i, j); encoding 3 falls into the P8 case.
    function automatic logic [3:0] shamt(input prec_t prec, input int unsigned i, input int unsigned j);
        case (prec)
            P2:      shamt = 4'd0;
            P4:      shamt = 4'(2 * ((i % 2) + (j % 2)));
            default: shamt = 4'(2 * (i + j));
        endcase
    endfunction

endpackage

// File: rtl/fusion_shift_add.sv
// Combinational sign-extend / shift / sum tree folding NBB BitBrick products into one beat sum.
module fusion_shift_add
    import sa_fusion_pkg::*;
#(
    parameter int NBB   = 16,
    parameter int SUM_W = 20
) (
    input  logic [NBB*BB_W-1:0] pp_i,
    input  logic [1:0]          prec_i,
    output logic [SUM_W-1:0]    sum_o
);

    always_comb begin
        sum_o = '0;
        for (int k = 0; k < NBB; k++) begin
            sum_o = sum_o + (SUM_W'(signed'(pp_i[k*BB_W +: BB_W]))
                             << shamt(prec_t'(prec_i), k / GRID, k % GRID));
        end
    end

endmodule

// File: rtl/bitbrick_fusion_acc.sv
// Fused-PE back end: per-beat shift/add reduction, then dot-product accumulation.
// Optional BITBRICK_ACC_SAT_EN clamps the accumulator on overflow instead of wrapping.
module bitbrick_fusion_acc
    import sa_fusion_pkg::*;
#(
    parameter int NBB   = 16,
    parameter int SUM_W = 20,
    parameter int ACC_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NBB*BB_W-1:0] in_pp,
    input  logic [1:0]          in_prec,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_data,
    output logic                out_ovf
);

    // Handshake: a beat moves on a rising edge where in_valid & in_ready; a result moves where
    // out_valid & out_ready. A held result (out_valid & ~out_ready) freezes the whole pipeline.
    logic [SUM_W-1:0] beat_sum;
    logic             stall;
    logic             accept;

    logic             s1_valid_q;
    logic             s1_last_q;
    logic [SUM_W-1:0] s1_sum_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_sticky_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_data_q;
    logic             out_ovf_q;

    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] acc_raw;
    logic             ovf_now;

    fusion_shift_add #(
        .NBB   (NBB),
        .SUM_W (SUM_W)
    ) u_shift_add (
        .pp_i   (in_pp),
        .prec_i (in_prec),
        .sum_o  (beat_sum)
    );

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        sum_ext = ACC_W'(signed'(s1_sum_q));
        acc_raw = acc_q + sum_ext;
        ovf_now = (acc_q[ACC_W-1] == sum_ext[ACC_W-1]) && (acc_raw[ACC_W-1] != acc_q[ACC_W-1]);
        acc_d   = acc_raw;
`ifdef BITBRICK_ACC_SAT_EN
        if (ovf_now) begin
            acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_sum_q     <= '0;
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ovf_q    <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_sum_q  <= beat_sum;
                s1_last_q <= in_last;
            end

            if (s1_valid_q && s1_last_q) begin
                out_data_q   <= acc_d;
                out_valid_q  <= 1'b1;
                out_ovf_q    <= ovf_sticky_q | ovf_now;
                acc_q        <= '0;
                ovf_sticky_q <= 1'b0;
            end else begin
                // Not stalled here, so any visible result is being drained this edge.
                out_valid_q <= 1'b0;
                if (s1_valid_q) begin
                    acc_q        <= acc_d;
                    ovf_sticky_q <= ovf_sticky_q | ovf_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitbrick_fusion_acc.sv
// Directed bench for bitbrick_fusion_acc (32-bit instance plus an 8-bit instance for overflow).
module tb_bitbrick_fusion_acc;

    logic        clock;
    logic        reset;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [95:0] in_pp;
    logic [1:0]  in_prec;
    logic [31:0] out_data;

    logic        in_valid8, in_ready8, in_last8, out_valid8, out_ready8, out_ovf8;
    logic [95:0] in_pp8;
    logic [1:0]  in_prec8;
    logic [7:0]  out_data8;

    int n_checks = 0;
    int n_fail   = 0;

    bitbrick_fusion_acc #(.NBB(16), .SUM_W(20), .ACC_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pp     (in_pp),
        .in_prec   (in_prec),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    bitbrick_fusion_acc #(.NBB(16), .SUM_W(20), .ACC_W(8)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_pp     (in_pp8),
        .in_prec   (in_prec8),
        .in_last   (in_last8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .out_ovf   (out_ovf8)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference BitBrick model: 8x8 signed operands split into 2-bit slices, top slice signed.
    function automatic logic [95:0] pp_p8(input int x, input int y);
        logic [95:0] r;
        int xs, ys;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                xs = (x >>> (2 * i)) & 3;
                ys = (y >>> (2 * j)) & 3;
                if (i == 3 && xs > 1) xs -= 4;
                if (j == 3 && ys > 1) ys -= 4;
                r[(4*i+j)*6 +: 6] = 6'(xs * ys);
            end
        end
        return r;
    endfunction

    // Four 4x4 signed pairs, pair q occupying grid quadrant q = 2*(i/2) + (j/2).
    function automatic logic [95:0] pp_p4(input int x0, input int y0, input int x1, input int y1,
                                          input int x2, input int y2, input int x3, input int y3);
        logic [95:0] r;
        int xa[4];
        int ya[4];
        int xs, ys, q;
        xa[0] = x0; xa[1] = x1; xa[2] = x2; xa[3] = x3;
        ya[0] = y0; ya[1] = y1; ya[2] = y2; ya[3] = y3;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                q  = 2 * (i / 2) + (j / 2);
                xs = (xa[q] >>> (2 * (i % 2))) & 3;
                ys = (ya[q] >>> (2 * (j % 2))) & 3;
                if ((i % 2) == 1 && xs > 1) xs -= 4;
                if ((j % 2) == 1 && ys > 1) ys -= 4;
                r[(4*i+j)*6 +: 6] = 6'(xs * ys);
            end
        end
        return r;
    endfunction

    // Driver: presents one beat from posedge+1 and returns at posedge+1 after it is taken.
    task automatic send_beat(input logic [95:0] pp, input logic [1:0] prec, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_pp    = pp;
        in_prec  = prec;
        in_last  = last;
        @(negedge clock);
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(output logic [31:0] d, output logic o, output bit got);
        got = 1'b0;
        d   = '0;
        o   = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock);
            if (out_valid) begin
                got = 1'b1;
                d   = out_data;
                o   = out_ovf;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;  in_pp  = '0; in_prec  = 2'd0; in_last  = 1'b0; out_ready  = 1'b1;
        in_valid8  = 1'b0;  in_pp8 = '0; in_prec8 = 2'd0; in_last8 = 1'b0; out_ready8 = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_checks++;
        if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        n_checks++;
        if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %0b want 0", out_ovf); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_p8_latency();
        logic [31:0] d;
        logic        o;
        bit          got;
        in_valid = 1'b1; in_pp = pp_p8(-3, 5); in_prec = 2'd2; in_last = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL p8_early_valid: got %0b want 0", out_valid); end
        @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL p8_latency_valid: got %0b want 1", out_valid); end
        n_checks++;
        if (out_data !== -32'sd15) begin n_fail++; $display("FAIL p8_data: got %0d want -15", $signed(out_data)); end
        n_checks++;
        if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL p8_ovf: got %0b want 0", out_ovf); end
        @(posedge clock);
        #1;
        // Precision code 3 behaves as P8.
        send_beat(pp_p8(-3, 5), 2'd3, 1'b1);
        wait_result(d, o, got);
        n_checks++;
        if (!got || d !== -32'sd15) begin
            n_fail++; $display("FAIL prec3_as_p8: got %0d (valid %0b) want -15", $signed(d), got);
        end
    endtask

    task automatic test_p2_accumulate();
        logic [31:0] d;
        logic        o;
        bit          got;
        send_beat({16{6'd1}}, 2'd0, 1'b0);
        send_beat({16{6'd1}}, 2'd0, 1'b0);
        send_beat({16{6'd1}}, 2'd0, 1'b1);
        wait_result(d, o, got);
        n_checks++;
        if (!got || d !== 32'd48) begin n_fail++; $display("FAIL p2_sum: got %0d (valid %0b) want 48", $signed(d), got); end
        send_beat(96'd5, 2'd0, 1'b1);
        wait_result(d, o, got);
        n_checks++;
        if (!got || d !== 32'd5) begin n_fail++; $display("FAIL p2_acc_cleared: got %0d (valid %0b) want 5", $signed(d), got); end
    endtask

    task automatic test_p4();
        logic [31:0] d;
        logic        o;
        bit          got;
        send_beat(pp_p4(7, 7, -8, 7, 3, -2, -1, -1), 2'd1, 1'b1);
        wait_result(d, o, got);
        n_checks++;
        if (!got || d !== -32'sd12) begin n_fail++; $display("FAIL p4_sum: got %0d (valid %0b) want -12", $signed(d), got); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] held;
        logic [31:0] exp;
        bit          held_ok;
        int          sent, got, stall_cyc;
        held = '0; held_ok = 1'b0; sent = 0; got = 0; stall_cyc = 0;
        for (int c = 0; c < 80 && got < 6; c++) begin
            out_ready = (c >= 8);
            if (sent < 6) begin
                in_valid = 1'b1; in_pp = 96'(sent + 1); in_prec = 2'd0; in_last = 1'b1;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(negedge clock);
            if (out_valid && !out_ready) begin
                stall_cyc++;
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0b want 0", in_ready); end
                if (held_ok) begin
                    n_checks++;
                    if (out_data !== held) begin n_fail++; $display("FAIL stall_data_hold: got %0d want %0d", out_data, held); end
                end
                held = out_data; held_ok = 1'b1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(sent + 1));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got %0d want none", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin n_fail++; $display("FAIL b2b_data: got %0d want %0d", out_data, exp); end
                end
                got++;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (stall_cyc < 5) begin n_fail++; $display("FAIL stall_cycles: got %0d want >=5", stall_cyc); end
        n_checks++;
        if (got != 6 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d results (%0d pending) want 6 (0)", got, exp_q.size());
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_duplicate: out_valid %0b want 0", out_valid); end
        @(posedge clock);
        #1;
    endtask

    task automatic send8(input logic [95:0] pp, input logic last);
        int guard;
        guard = 0;
        in_valid8 = 1'b1; in_pp8 = pp; in_prec8 = 2'd2; in_last8 = last;
        @(negedge clock);
        while (!in_ready8 && guard < 50) begin @(negedge clock); guard++; end
        @(posedge clock);
        #1;
        in_valid8 = 1'b0; in_last8 = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp8;
        logic [7:0] d8;
        logic       o8;
        bit         got;
`ifdef BITBRICK_ACC_SAT_EN
        exp8 = 8'sd127;
`else
        exp8 = -8'sd56;
`endif
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                send8(pp_p8(10, 10), 1'b0);
                send8(pp_p8(10, 10), 1'b1);
            end else begin
                send8(pp_p8(1, 1), 1'b1);
            end
            got = 1'b0; d8 = '0; o8 = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clock);
                if (out_valid8) begin got = 1'b1; d8 = out_data8; o8 = out_ovf8; end
            end
            @(posedge clock);
            #1;
            if (r == 0) begin
                n_checks++;
                if (!got || d8 !== exp8) begin n_fail++; $display("FAIL ovf_data: got %0d (valid %0b) want %0d", $signed(d8), got, $signed(exp8)); end
                n_checks++;
                if (o8 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", o8); end
            end else begin
                n_checks++;
                if (!got || d8 !== 8'd1 || o8 !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_cleared: got %0d ovf %0b want 1 ovf 0", $signed(d8), o8);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] d;
        logic        o;
        bit          got;
        send_beat({16{6'd1}}, 2'd0, 1'b0);
        send_beat({16{6'd1}}, 2'd0, 1'b0);
        reset = 1'b1;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0) begin
            n_fail++; $display("FAIL midreset_outputs: valid %0b data %0d want 0 0", out_valid, out_data);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_beat({4{6'd1}}, 2'd0, 1'b0);
        send_beat({4{6'd1}}, 2'd0, 1'b1);
        wait_result(d, o, got);
        n_checks++;
        if (!got || d !== 32'd8) begin n_fail++; $display("FAIL midreset_result: got %0d (valid %0b) want 8", $signed(d), got); end
    endtask

    initial begin
        test_reset();
        test_p8_latency();
        test_p2_accumulate();
        test_p4();
        test_back_to_back();
        test_overflow();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
